jtcomsc_snd_comm: RTL



---
 rtl/jtcomsc_pkg.sv | 5 +
 rtl/jtcomsc_snd_fifo.sv | 58 +++++
 rtl/jtcomsc_snd_comm.sv | 50 +++++
 3 files changed

// File: rtl/jtcomsc_pkg.sv
// jtcomsc_pkg: shared sound-command channel types and defaults
package jtcomsc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, SERV = 2'd2} snd_st_e;
  localparam int SND_FIFO_AW = 2;
endpackage

// File: rtl/jtcomsc_snd_fifo.sv
// jtcomsc_snd_fifo: command storage with registered head byte
// JTCOMSC_SND_FIFO_EN selects a 2**FIFO_AW deep FIFO; otherwise a single latest-wins latch
module jtcomsc_snd_fifo
  import jtcomsc_pkg::*;
#(
  parameter int FIFO_AW = SND_FIFO_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       din,
  output logic [7:0]       dout,
  output logic [FIFO_AW:0] level,
  output logic             ovf
);
`ifdef JTCOMSC_SND_FIFO_EN
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [FIFO_AW:0] level_n;
  logic [7:0] head_n;
  logic pop_ok, push_ok;
  // a pop frees a slot in the same clk, so a full push alongside it is accepted
  always_comb begin
    pop_ok  = pop && level != '0;
    push_ok = push && (!level[FIFO_AW] || pop_ok);
    rd_n    = rd_ptr + FIFO_AW'(pop_ok);
    level_n = level + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);
    head_n  = push_ok && wr_ptr == rd_n ? din : mem[rd_n];
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
      dout   <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(push_ok);
      rd_ptr <= rd_n;
      level  <= level_n;
      ovf    <= ovf | (push & ~push_ok);
      if (level_n != '0) dout <= head_n;
    end
`else
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout  <= '0;
      level <= '0;
    end else begin
      if (push) dout <= din;
      level <= push ? (FIFO_AW+1)'(1) : pop ? '0 : level;
    end
  assign ovf = 1'b0;
`endif
endmodule

// File: rtl/jtcomsc_snd_comm.sv
// jtcomsc_snd_comm: main-to-sound command channel driving the sound Z80 INT line
// Storage depth depends on JTCOMSC_SND_FIFO_EN (see jtcomsc_snd_fifo)
module jtcomsc_snd_comm
  import jtcomsc_pkg::*;
#(
  parameter int FIFO_AW = SND_FIFO_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snd_irq,
  input  logic [7:0]       snd_latch,
  input  logic             snd_cen,
  input  logic             latch_rd,
  input  logic             irq_ack,
  output logic [7:0]       snd_din,
  output logic             snd_int_n,
  output logic [FIFO_AW:0] level,
  output logic             ovf
);
  snd_st_e st, st_n;
  logic lrd_q, pop, ack;
  // retire on the trailing edge of the read so the byte stays put during the access
  assign pop       = snd_cen & lrd_q & ~latch_rd;
  assign ack       = snd_cen & irq_ack;
  assign snd_int_n = st != PEND;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lrd_q <= 1'b0;
      st    <= IDLE;
    end else begin
      if (snd_cen) lrd_q <= latch_rd;
      st <= st_n;
    end
  always_comb begin
    st_n = IDLE;
    st_n = st == IDLE ? (level != '0 ? PEND : IDLE) :
           st == PEND ? (pop ? IDLE : ack ? SERV : PEND) :
           st == SERV ? (pop ? IDLE : SERV) : IDLE;
  end
  jtcomsc_snd_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (snd_irq),
    .pop   (pop),
    .din   (snd_latch),
    .dout  (snd_din),
    .level (level),
    .ovf   (ovf)
  );
endmodule
